// File: rtl/chip_74ls191_sync.sv
// Presettable WIDTH-bit synchronous up/down counter modelled on the 74LS191.
// MAX_MIN and RCO_n decode the terminal state so that stages can be cascaded.
module chip_74ls191_sync #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLR_n,
   input  logic             LOAD_n,
   input  logic             CTEN_n,
   input  logic             D_U,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             MAX_MIN,
   output logic             RCO_n
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;
   logic             w_maxMin;

   // Load beats counting; D_U is sampled at the edge, so a direction change never needs extra state.
   always_comb begin
      w_next = r_q;
      if (!LOAD_n) begin
         w_next = D;
      end else if (!CTEN_n) begin
         w_next = D_U ? (r_q - ONE) : (r_q + ONE);
      end
   end

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_next;
      end
   end

   // Terminal-count decode follows D_U combinationally; RCO_n pulses in the CLK-low half to clock the next stage.
   assign w_maxMin = D_U ? (r_q == '0) : (r_q == ALL_ONES);

   assign Q       = r_q;
   assign MAX_MIN = w_maxMin;
   assign RCO_n   = ~(w_maxMin & ~CTEN_n & ~CLK);

endmodule

// File: tb/tb_chip_74ls191_sync.sv
// Self-checking bench for chip_74ls191_sync: directed test-plan scenarios, randomized
// stimulus against a modulo-arithmetic counter model, and a two-stage cascade.
module tb_chip_74ls191_sync;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         CLK;
   logic         CLR_n;
   logic         LOAD_n;
   logic         CTEN_n;
   logic         D_U;
   logic [W-1:0] D;
   logic [W-1:0] Q;
   logic         MAX_MIN;
   logic         RCO_n;

   logic         casClrN;
   logic         casCten;
   logic [W-1:0] loQ;
   logic [W-1:0] hiQ;
   logic         loMm;
   logic         hiMm;
   logic         loRco;
   logic         hiRco;

   int mq;
   int checks;
   int passes;
   bit checkEn;

   chip_74ls191_sync #(.WIDTH(W)) dut (
      .CLK(CLK), .CLR_n(CLR_n), .LOAD_n(LOAD_n), .CTEN_n(CTEN_n), .D_U(D_U),
      .D(D), .Q(Q), .MAX_MIN(MAX_MIN), .RCO_n(RCO_n)
   );

   chip_74ls191_sync #(.WIDTH(W)) uLo (
      .CLK(CLK), .CLR_n(casClrN), .LOAD_n(1'b1), .CTEN_n(casCten), .D_U(1'b0),
      .D('0), .Q(loQ), .MAX_MIN(loMm), .RCO_n(loRco)
   );

   chip_74ls191_sync #(.WIDTH(W)) uHi (
      .CLK(loRco), .CLR_n(casClrN), .LOAD_n(1'b1), .CTEN_n(casCten), .D_U(1'b0),
      .D('0), .Q(hiQ), .MAX_MIN(hiMm), .RCO_n(hiRco)
   );

   initial begin
      CLK = 1'b0;
      forever #10 CLK = ~CLK;
   end

   // Reference model: counter value as plain modulo arithmetic.
   initial mq = 0;
   always @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n)            mq = 0;
      else if (!LOAD_n)      mq = int'(D);
      else if (!CTEN_n)      mq = D_U ? (mq + MOD - 1) % MOD : (mq + 1) % MOD;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Compare process: every half cycle, 1 time unit after the CLK transition.
   always @(CLK) begin
      bit expMm;
      #1;
      if (checkEn) begin
         expMm = D_U ? (mq == 0) : (mq == MOD - 1);
         checkOutput("model Q", int'(Q), mq);
         checkOutput("model MAX_MIN", int'(MAX_MIN), int'(expMm));
         checkOutput("model RCO_n", int'(RCO_n), int'(!(expMm && !CTEN_n && !CLK)));
      end
   end

   // Called at posedge+2 (CLK high); applies inputs and returns at posedge+2 after one edge.
   task automatic applyStimulus(input logic ld, input logic [W-1:0] d, input logic ct,
                                input logic du, input bit clrPulse);
      LOAD_n = ld;
      D      = d;
      CTEN_n = ct;
      D_U    = du;
      if (clrPulse) begin
         #10 CLR_n = 1'b0;
         #3  CLR_n = 1'b1;
      end
      @(posedge CLK);
      #2;
   endtask

   initial begin
      checks  = 0;
      passes  = 0;
      checkEn = 0;
      CLR_n   = 1'b0;
      LOAD_n  = 1'b1;
      CTEN_n  = 1'b1;
      D_U     = 1'b0;
      D       = '0;
      casClrN = 1'b0;
      casCten = 1'b1;

      @(posedge CLK);
      #2;
      checkOutput("reset Q", int'(Q), 0);
      checkOutput("reset MAX_MIN up", int'(MAX_MIN), 0);
      D_U = 1'b1;
      #1;
      checkOutput("reset MAX_MIN down", int'(MAX_MIN), 1);
      D_U = 1'b0;
      CLR_n = 1'b1;
      checkEn = 1;
      @(posedge CLK);
      #2;

      // Reset mid-count: up 0..9, then a 3-unit clear pulse in the CLK-low half.
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("count to 9", int'(Q), 9);
      #10 CLR_n = 1'b0;
      #1  checkOutput("async clear", int'(Q), 0);
      #2  CLR_n = 1'b1;
      @(posedge CLK);
      #2;
      checkOutput("first edge after clear", int'(Q), 1);

      // Up wrap through F.
      applyStimulus(1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
      checkOutput("load E", int'(Q), 14);
      checkOutput("MAX_MIN at E", int'(MAX_MIN), 0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("up to F", int'(Q), 15);
      checkOutput("MAX_MIN at F", int'(MAX_MIN), 1);
      checkOutput("RCO_n high half", int'(RCO_n), 1);
      #10;
      checkOutput("RCO_n low half", int'(RCO_n), 0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("up wrap 0", int'(Q), 0);
      checkOutput("MAX_MIN at 0 up", int'(MAX_MIN), 0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("up to 1", int'(Q), 1);

      // Down wrap through 0.
      applyStimulus(1'b0, 4'h1, 1'b1, 1'b1, 1'b0);
      checkOutput("load 1", int'(Q), 1);
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("down to 0", int'(Q), 0);
      checkOutput("MAX_MIN at 0 down", int'(MAX_MIN), 1);
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("down wrap F", int'(Q), 15);
      checkOutput("MAX_MIN at F down", int'(MAX_MIN), 0);
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("down to E", int'(Q), 14);

      // Hold, then load beats count on the same edge.
      applyStimulus(1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
         checkOutput("hold 5", int'(Q), 5);
      end
      applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
      checkOutput("load over count", int'(Q), 10);

      // Direction flip at terminal count with no clock edge.
      applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
      checkOutput("MAX_MIN F up", int'(MAX_MIN), 1);
      D_U = 1'b1;
      #1;
      checkOutput("MAX_MIN after flip", int'(MAX_MIN), 0);
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("down after flip", int'(Q), 14);

      // Randomized phase with occasional asynchronous clears.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) != 0), W'($urandom_range(0, MOD - 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 29) == 0));
      end

      // Cascade: low stage's RCO_n clocks the high stage.
      casCten = 1'b0;
      casClrN = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         #2;
         if (i == 15) checkOutput("cascade hi before wrap", int'(hiQ), 0);
         if (i == 16) checkOutput("cascade hi after wrap", int'(hiQ), 1);
      end
      checkOutput("cascade value", int'({hiQ, loQ}), 8'h14);

      checkEn = 0;
      #5;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
